// File: rtl/echo_pkg.sv
// Shared definitions for the feedback echo stage: FSM states, gain format
// and default-width saturation limits.
package echo_pkg;

    // Number of fractional bits in the Q1.5 gain.
    localparam int unsigned GAIN_FRAC = 5;

    // Default sample width; the saturation limits below follow from it.
    localparam int unsigned DEFAULT_DATA_WIDTH = 16;
    localparam int SAT_MAX = (2 ** (DEFAULT_DATA_WIDTH - 1)) - 1;
    localparam int SAT_MIN = -(2 ** (DEFAULT_DATA_WIDTH - 1));

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        RD,
        MUL,
        ACC,
        WR
    } state_t;

endpackage

// File: rtl/dp_ram_sync.sv
// Simple dual-port RAM: one write port, one registered read port, one clock.
// No reset on the array so it maps onto block RAM.
module dp_ram_sync #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port, one cycle of latency.
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/echo_delay_line.sv
// Single-channel feedback echo: out = sat(in + (tap * gain) >>> 5), where tap
// is the buffer word delay_len samples back; the result is written back into
// the circular buffer and emitted downstream. One sample per 5 clocks.
module echo_delay_line
    import echo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned GAIN_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [GAIN_WIDTH-1:0] gain,
    input  logic [ADDR_WIDTH-1:0] delay_len,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  drop
);

    localparam int unsigned PW = DATA_WIDTH + GAIN_WIDTH;
    // Saturation bounds at product width: 2^(DW-1)-1 and its complement.
    localparam logic signed [PW-1:0] SAT_HI = (PW'(1) <<< (DATA_WIDTH - 1)) - PW'(1);
    localparam logic signed [PW-1:0] SAT_LO = ~SAT_HI;

    state_t state;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic signed [DATA_WIDTH-1:0] in_q;
    logic signed [GAIN_WIDTH-1:0] gain_q;
    logic        [ADDR_WIDTH-1:0] dly_q;
    logic signed [PW-1:0]         prod_q;
    logic        [DATA_WIDTH-1:0] sat_q;

    logic signed [DATA_WIDTH-1:0] tap;
    logic signed [PW-1:0]         prod_d;
    logic signed [PW-1:0]         sum_d;
    logic        [DATA_WIDTH-1:0] sat_d;

    // Tap address wraps naturally modulo the buffer depth.
    assign rd_addr = wr_ptr - dly_q;

    dp_ram_sync #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // Datapath: bypass tap, full-width product, floor-scaled sum, saturation.
    always_comb begin
        tap    = (dly_q == '0) ? '0 : $signed(ram_rdata);
        prod_d = tap * gain_q;
        sum_d  = PW'(in_q) + (prod_q >>> GAIN_FRAC);
        if (sum_d > SAT_HI) begin
            sat_d = DATA_WIDTH'(SAT_HI);
        end else if (sum_d < SAT_LO) begin
            sat_d = DATA_WIDTH'(SAT_LO);
        end else begin
            sat_d = DATA_WIDTH'(sum_d);
        end
    end

    // Buffer write port: zero-fill during CLEAR, mixed sample during WR.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wr_ptr;
        ram_wdata = '0;
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt;
        end else if (state == WR) begin
            ram_we    = 1'b1;
            ram_wdata = sat_q;
        end
    end

    // Control FSM with registered outputs and pipeline registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CLEAR;
            wr_ptr    <= '0;
            clr_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b1;
            drop      <= 1'b0;
            in_q      <= '0;
            gain_q    <= '0;
            dly_q     <= '0;
            prod_q    <= '0;
            sat_q     <= '0;
        end else begin
            out_valid <= 1'b0;
            drop      <= in_valid && (state != IDLE);
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (in_valid) begin
                        in_q   <= $signed(in_data);
                        gain_q <= $signed(gain);
                        dly_q  <= delay_len;
                        state  <= RD;
                        busy   <= 1'b1;
                    end
                end
                RD: begin
                    state <= MUL;
                end
                MUL: begin
                    prod_q <= prod_d;
                    state  <= ACC;
                end
                ACC: begin
                    sat_q <= sat_d;
                    state <= WR;
                end
                WR: begin
                    wr_ptr    <= wr_ptr + 1'b1;
                    out_data  <= sat_q;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state   <= CLEAR;
                    clr_cnt <= '0;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_echo_delay_line.sv
// Self-checking bench for echo_delay_line against an array-based echo model.
module tb_echo_delay_line;
    import echo_pkg::*;

    localparam int DW    = 16;
    localparam int AW    = 12;
    localparam int GW    = 6;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [GW-1:0] gain;
    logic [AW-1:0] delay_len;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          drop;

    always #5 clk = ~clk;

    echo_delay_line #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .GAIN_WIDTH (GW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .gain      (gain),
        .delay_len (delay_len),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .drop      (drop)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: the echo history as plain integers.
    int model_mem [DEPTH];
    int model_wp;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;
        model_wp = 0;
    endtask

    function automatic int floor_div32(input int p);
        if (p >= 0) return p / 32;
        return -((-p + 31) / 32);
    endfunction

    function automatic int model_step(input int x, input int g, input int d);
        int tap;
        int y;
        tap = (d == 0) ? 0 : model_mem[(model_wp - d + DEPTH) % DEPTH];
        y   = x + floor_div32(tap * g);
        if (y > SAT_MAX) y = SAT_MAX;
        if (y < SAT_MIN) y = SAT_MIN;
        model_mem[model_wp] = y;
        model_wp = (model_wp + 1) % DEPTH;
        return y;
    endfunction

    function automatic int gain_value(input int gbits);
        return (gbits >= 32) ? gbits - 64 : gbits;
    endfunction

    // Assert reset, check reset outputs, release and time the CLEAR phase.
    task automatic do_reset();
        int cnt;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_out_data", int'($signed(out_data)), 0);
        check_eq("rst_busy", int'(busy), 1);
        check_eq("rst_drop", int'(drop), 0);
        model_reset();
        reset_n = 1'b1;
        cnt = 0;
        while (busy && cnt < 5000) begin
            cnt++;
            @(negedge clk);
        end
        check_eq("clear_cycles", cnt, DEPTH);
    endtask

    // Send one sample (starting at a negedge) and check latency and value.
    task automatic send(input int x, input int gbits, input int d, output int got);
        int lat;
        int exp;
        int xv;
        int gv;
        int dv;
        xv = x;
        gv = gbits;
        dv = d;
        in_valid  = 1'b1;
        in_data   = xv[DW-1:0];
        gain      = gv[GW-1:0];
        delay_len = dv[AW-1:0];
        @(negedge clk);
        in_valid = 1'b0;
        exp = model_step(x, gain_value(gbits), d);
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        got = int'($signed(out_data));
        check_eq("latency", lat, 4);
        check_eq("out_data", got, exp);
    endtask

    task automatic flush();
        int got;
        for (int i = 0; i < 8; i++) send(0, 0, 0, got);
    endtask

    int got;
    int imp_exp [12] = '{32767, 0, 0, 0, 31743, 0, 0, 0, 30751, 0, 0, 0};
    int neg_exp [5]  = '{1000, 0, -1000, 0, 1000};

    initial begin
        int n_drop;
        int n_ov;
        int ov_val;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        gain      = '0;
        delay_len = '0;

        do_reset();

        // Cleared buffer: every tap address reads 0.
        for (int d = 0; d < DEPTH; d++) begin
            send(0, 31, d, got);
        end

        // Impulse echo, delay 4, gain 31/32.
        for (int i = 0; i < 12; i++) begin
            send((i == 0) ? 32767 : 0, 31, 4, got);
            check_eq("impulse", got, imp_exp[i]);
        end

        // Positive saturation.
        flush();
        for (int i = 0; i < 6; i++) begin
            send(30000, 31, 1, got);
            check_eq("sat_pos", got, (i == 0) ? 30000 : 32767);
        end

        // Negative saturation.
        flush();
        for (int i = 0; i < 6; i++) begin
            send(-30000, 31, 1, got);
            check_eq("sat_neg", got, (i == 0) ? -30000 : -32768);
        end

        // Gain of -1.
        flush();
        for (int i = 0; i < 5; i++) begin
            send((i == 0) ? 1000 : 0, 32, 2, got);
            check_eq("neg_gain", got, neg_exp[i]);
        end

        // Second strobe two cycles into a sample is dropped.
        in_valid  = 1'b1;
        in_data   = 16'd1234;
        gain      = 6'd0;
        delay_len = 12'd0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'd777;
        void'(model_step(1234, 0, 0));
        n_drop = 0;
        n_ov   = 0;
        ov_val = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (drop) n_drop++;
            if (out_valid) begin
                n_ov++;
                ov_val = int'($signed(out_data));
            end
        end
        check_eq("drop_pulses", n_drop, 1);
        check_eq("drop_outputs", n_ov, 1);
        check_eq("drop_value", ov_val, 1234);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            int x;
            int g;
            int d;
            x = int'($urandom_range(0, 65535)) - 32768;
            g = int'($urandom_range(0, 63));
            d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, DEPTH - 1))
                                            : int'($urandom_range(0, 12));
            send(x, g, d, got);
        end

        // Reset during MUL aborts the sample.
        in_valid  = 1'b1;
        in_data   = 16'd5000;
        gain      = 6'd31;
        delay_len = 12'd3;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("abort_out_valid", int'(out_valid), 0);
        check_eq("abort_out_data", int'($signed(out_data)), 0);
        check_eq("abort_busy", int'(busy), 1);
        n_ov = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) n_ov++;
        end
        check_eq("abort_no_output", n_ov, 0);
        do_reset();

        // Clean echo after re-clear.
        for (int i = 0; i < 12; i++) begin
            send((i == 0) ? 32767 : 0, 31, 4, got);
            check_eq("post_clear_impulse", got, imp_exp[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/echo_delay_line.md
# echo_delay_line

Single-channel feedback echo stage for the audio loopback path. It sits between the ADC FIFO read side and the per-channel low-pass filter; one instance is used per stereo half. Each accepted sample is mixed with a gain-scaled tap read from a circular delay buffer. The saturated result is written back into the buffer, which is what makes the echo decay, and is also emitted downstream.

## Interface
- DATA_WIDTH, 16: sample width, signed two's complement.
- ADDR_WIDTH, 12: delay buffer address width; depth = 2^ADDR_WIDTH words.
- GAIN_WIDTH, 6: signed gain width. Format Q1.5: 6'b011111 = 31/32, 6'b100000 = -1.
- clk  in  1  system clock. Same domain as FIFO read/write logic.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  one-cycle sample strobe.
- in_data  in  DATA_WIDTH  input sample, signed.
- gain  in  GAIN_WIDTH  feedback gain, signed Q1.5. Sampled with in_valid.
- delay_len  in  ADDR_WIDTH  echo delay in samples. Sampled with in_valid.
- out_valid  out  1  one-cycle strobe; out_data is valid in that cycle.
- out_data  out  DATA_WIDTH  mixed, saturated sample. Held until the next out_valid.
- busy  out  1  high during CLEAR and while a sample is in flight.
- drop  out  1  one-cycle pulse when in_valid arrives while busy. That sample is discarded.

## Operation
- FSM states: CLEAR, IDLE, RD, MUL, ACC, WR.
- Reset entry:
  - State goes to CLEAR.
  - Outputs on reset: out_valid=0, out_data=0, busy=1, drop=0.
  - wr_ptr=0, clear counter=0.
- CLEAR:
  - Writes 0 to every buffer address, one address per cycle, 2^ADDR_WIDTH cycles in total.
  - Moves to IDLE after the last address is written.
- IDLE:
  - busy=0.
  - On in_valid, latch in_data, gain and delay_len, then go to RD.
- RD:
  - Read address = wr_ptr − delay_len, modulo 2^ADDR_WIDTH (natural wrap).
- MUL:
  - prod = tap × gain. This is a full-width signed product of DATA_WIDTH+GAIN_WIDTH bits.
  - scaled = prod >>> 5 (arithmetic shift, floor).
- ACC:
  - sum = in + scaled, computed at DATA_WIDTH+1 bits or wider.
  - Saturate to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- WR:
  - Write the saturated sum at wr_ptr.
  - wr_ptr increments with wrap.
  - Register out_data and pulse out_valid on the following cycle.
  - Return to IDLE.
- delay_len = 0 is bypass: the tap is forced to 0, so out = in. The buffer is still written with in.
- in_valid seen in any state other than IDLE pulses drop. State, pointer and buffer are unaffected.
- Reset asserted mid-operation aborts the in-flight sample with no output, and CLEAR restarts from address 0.

## Timing
- Edge 0 is the edge at which in_valid is sampled in IDLE.
- States: RD at edges 0→1, MUL 1→2, ACC 2→3, WR 3→4.
- out_valid is high in the cycle after edge 4: latency is 4 clocks, throughput is 1 sample per 5 clocks.
- The next in_valid may be accepted in the cycle out_valid is high, because the FSM is already in IDLE.
- RAM read is registered (1-cycle latency). A write and a read in the same cycle never target the same address within one sample.
- CLEAR lasts exactly 2^ADDR_WIDTH cycles after reset release. busy falls in the first IDLE cycle.
- Sample rate is ~48 kHz and clk is ≥25 MHz, so drops never occur in normal operation.

## Structure
- Shared package echo_pkg holds:
  - GAIN_FRAC = 5
  - the state enumeration
  - saturation helper constants SAT_MAX and SAT_MIN, derived from DATA_WIDTH
- One sub-module, dp_ram_sync:
  - simple dual-port, 2^ADDR_WIDTH × DATA_WIDTH
  - one write port, one registered read port, single clock
  - inferable as block RAM, no reset on the array

## Test plan
- Reset release → busy=1 for 4096 cycles, then 0. A subsequent bypass read path returns 0 from every address, checked by sweeping delay_len with in=0: out=0 each time.
- Impulse test, delay_len=4, gain=6'b011111, inputs 32767 followed by zeros:
  - output 32767 at sample 0
  - 31743 at sample 4
  - 30751 at sample 8
  - 0 elsewhere
- Saturation test, delay_len=1, gain=6'b011111, in=30000 constant:
  - sample 1 computes 30000+29062 and outputs 32767
  - stays at 32767
  - the negative mirror case clamps to −32768
- Negative gain, delay_len=2, gain=6'b100000, in 1000 then 0 → outputs 1000, 0, −1000, 0, 1000.
- Busy drop: a second in_valid 2 cycles after the first → drop pulses once, and only one out_valid is produced.
- Reset pulsed at the MUL state → no out_valid, outputs return to reset values, CLEAR restarts. A post-clear impulse gives a clean echo with no stale tap.
